// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, shift-add multiply,
// and bit-serial shifts behind a valid/ready IDLE/EXEC/DONE sequencer.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned DW  = 2 * WIDTH;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic [CW-1:0]    cnt, cnt_load;
    logic [DW-1:0]    acc, mcand, prod_nxt;
    logic [WIDTH-1:0] sh_nxt, res_fin;
    logic [WIDTH:0]   add_full, sub_full;
    logic             carry_fin, shamt_nz, last, accept;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state and datapath combinational terms
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shamt_nz  = |b[SHW-1:0];
        last      = (cnt == CW'(1));
        add_full  = {1'b0, a} + {1'b0, b};
        sub_full  = {1'b0, a} - {1'b0, b};
        prod_nxt  = acc + (b[0] ? mcand : DW'(0));
        sh_nxt    = (op == OP_SLL) ? {a[WIDTH-2:0], 1'b0} : {a[WIDTH-1], a[WIDTH-1:1]};
        res_fin   = b;
        carry_fin = 1'b0;
        cnt_load  = CW'(1);

        case (operation)
            OP_MUL:         cnt_load = CW'(WIDTH);
            OP_SLL, OP_SRA: cnt_load = (|data2[SHW-1:0]) ? {1'b0, data2[SHW-1:0]} : CW'(1);
            default:        cnt_load = CW'(1);
        endcase

        case (op)
            OP_FWD: res_fin = b;
            OP_ADD: begin res_fin = add_full[WIDTH-1:0]; carry_fin = add_full[WIDTH]; end
            OP_AND: res_fin = a & b;
            OP_OR:  res_fin = a | b;
            OP_SUB: begin res_fin = sub_full[WIDTH-1:0]; carry_fin = sub_full[WIDTH]; end
            OP_MUL: begin res_fin = prod_nxt[WIDTH-1:0]; carry_fin = |prod_nxt[DW-1:WIDTH]; end
            default: res_fin = shamt_nz ? sh_nxt : a;
        endcase

        case (state)
            S_IDLE: if (in_valid) begin accept = 1'b1; state_nxt = S_EXEC; end
            S_EXEC: if (last) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers and result/flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a         <= '0;
            b         <= '0;
            op        <= OP_FWD;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
            if (accept) begin
                a     <= data1;
                b     <= data2;
                op    <= operation;
                cnt   <= cnt_load;
                acc   <= '0;
                mcand <= {WIDTH'(0), data1};
            end else if (state == S_EXEC) begin
                cnt <= cnt - CW'(1);
                if (op == OP_MUL) begin
                    acc   <= prod_nxt;
                    mcand <= {mcand[DW-2:0], 1'b0};
                    b     <= {1'b0, b[WIDTH-1:1]};
                end else if ((op == OP_SLL || op == OP_SRA) && shamt_nz) begin
                    a <= sh_nxt;
                end
                if (last) begin
                    result <= res_fin;
                    zero   <= (res_fin == '0);
                    carry  <= carry_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH 8/16/32: directed cases, backpressure, mid-op
// reset and random ops checked against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  iv;
    logic [31:0] d1, d2;
    logic [2:0]  opc;
    logic        ordy;
    logic [2:0]  ir_v, ov_v, z_v, c_v;
    logic [31:0] r_a [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = 8 << g;
        logic [W-1:0] r;
        alu_seq #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (iv[g]),
            .in_ready  (ir_v[g]),
            .data1     (d1[W-1:0]),
            .data2     (d2[W-1:0]),
            .operation (opc),
            .out_valid (ov_v[g]),
            .out_ready (ordy),
            .result    (r),
            .zero      (z_v[g]),
            .carry     (c_v[g])
        );
        assign r_a[g] = 32'(r);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result/carry/latency from the opcode definitions
    function automatic void model(input int w, input logic [2:0] o,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned r, output logic c, output int n);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned s, sa;
        int sh = int'(b % longint'(w));
        c = 1'b0;
        n = 1;
        case (o)
            3'd0: r = b;
            3'd1: begin s = a + b; r = s & mask; c = ((s >> w) & 1) != 0; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin r = (a - b) & mask; c = (a < b); end
            3'd5: begin s = a * b; r = s & mask; c = (s >> w) != 0; n = w; end
            3'd6: begin r = (a << sh) & mask; n = (sh == 0) ? 1 : sh; end
            default: begin
                sa = a[w-1] ? (a | ~mask) : a;
                r  = longint'($signed(sa) >>> sh) & mask;
                n  = (sh == 0) ? 1 : sh;
            end
        endcase
    endfunction

    task automatic wait_ready(input int sel);
        int k = 0;
        while (!ir_v[sel] && k < 100) begin @(posedge clk); #1; k++; end
        if (!ir_v[sel]) chk("ready_timeout", 64'(ir_v[sel]), 64'd1);
    endtask

    task automatic accept(input int sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        wait_ready(sel);
        @(negedge clk);
        d1 = a; d2 = b; opc = o; iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv = '0; d1 = $urandom; d2 = $urandom; opc = 3'($urandom);
        chk("in_ready_after_accept", 64'(ir_v[sel]), 64'd0);
    endtask

    // Full transaction; 'hold' cycles of backpressure with a stray in_valid pulse
    task automatic run(input int sel, input logic [2:0] o, input longint unsigned a0,
                       input longint unsigned b0, input int hold);
        int w = 8 << sel;
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned a = a0 & mask, b = b0 & mask, er;
        logic ec;
        int en, n;
        model(w, o, a, b, er, ec, en);
        accept(sel, o, 32'(a), 32'(b));
        n = 0;
        while (!ov_v[sel] && n < 200) begin @(posedge clk); #1; n++; end
        chk($sformatf("latency w%0d op%0d", w, o), 64'(n), 64'(en));
        chk($sformatf("result w%0d op%0d", w, o), 64'(r_a[sel]), 64'(er));
        chk($sformatf("zero w%0d op%0d", w, o), 64'(z_v[sel]), 64'(er == 0));
        chk($sformatf("carry w%0d op%0d", w, o), 64'(c_v[sel]), 64'(ec));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == 2) iv[sel] = 1'b1;
            @(posedge clk); #1;
            iv = '0;
            chk("bp_out_valid", 64'(ov_v[sel]), 64'd1);
            chk("bp_in_ready", 64'(ir_v[sel]), 64'd0);
            chk("bp_result", 64'(r_a[sel]), 64'(er));
            chk("bp_zero", 64'(z_v[sel]), 64'(er == 0));
            chk("bp_carry", 64'(c_v[sel]), 64'(ec));
        end
        @(negedge clk); ordy = 1'b1;
        @(posedge clk); #1; ordy = 1'b0;
        chk("idle_in_ready", 64'(ir_v[sel]), 64'd1);
        chk("idle_out_valid", 64'(ov_v[sel]), 64'd0);
        chk("idle_result_held", 64'(r_a[sel]), 64'(er));
        if (hold > 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk("stray_pulse_ignored", 64'(ov_v[sel]), 64'd0);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; iv = '0; ordy = 1'b0; d1 = '0; d2 = '0; opc = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_in_ready", 64'(ir_v[s]), 64'd1);
            chk("rst_out_valid", 64'(ov_v[s]), 64'd0);
            chk("rst_result", 64'(r_a[s]), 64'd0);
            chk("rst_flags", 64'({z_v[s], c_v[s]}), 64'd0);
        end
        @(negedge clk); reset_n = 1'b1;

        // Directed WIDTH=8
        run(0, 3'd1, 200, 100, 0);
        run(0, 3'd0, 0, 8'h5A, 0);
        run(0, 3'd4, 5, 5, 0);
        run(0, 3'd4, 3, 5, 0);
        run(0, 3'd5, 13, 11, 0);
        run(0, 3'd5, 16, 16, 0);
        run(0, 3'd7, 8'h80, 3, 0);
        run(0, 3'd6, 8'h01, 0, 0);
        run(0, 3'd6, 8'h01, 9, 0);
        run(0, 3'd2, 8'hF0, 8'h3C, 0);
        run(0, 3'd3, 8'hF0, 8'h0C, 0);
        run(0, 3'd1, 8'hFF, 8'h01, 5);

        // Reset in the 4th EXEC cycle of a MUL
        accept(0, 3'd5, 32'd13, 32'd11);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(ov_v[0]), 64'd0);
        chk("midrst_in_ready", 64'(ir_v[0]), 64'd1);
        chk("midrst_result", 64'(r_a[0]), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", 64'(ov_v[0]), 64'd0);
        end
        run(0, 3'd1, 7, 9, 0);

        // Wider datapaths, including carry boundaries
        for (int s = 1; s < 3; s++) begin
            longint unsigned ones = (64'd1 << (8 << s)) - 1;
            run(s, 3'd1, ones, 1, 0);
            run(s, 3'd1, 1234, 4321, 0);
            run(s, 3'd4, 3, 5, 0);
            run(s, 3'd4, 77, 77, 0);
            run(s, 3'd5, ones, ones, 0);
            run(s, 3'd5, 255, 3, 0);
            run(s, 3'd7, 64'd1 << ((8 << s) - 1), 5, 0);
        end

        // Random operations on every width
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 20; k++) begin
                run(s, 3'($urandom), {32'd0, $urandom}, {32'd0, $urandom}, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
